mem_dump_ctrl: RTL and testbench
================================

# mem_dump_ctrl

Hardware memory-dump engine: the read-out counterpart of image loading. On a start command it reads a contiguous range of words from the data-memory read port and streams them, with their addresses, on a valid/ready output interface toward a debug or host link. It sits beside the data memory inside CoreTop and gives an RTL path to extract a memory image at end of test or in silicon.

## Interface
- ADDR_W, 32: byte-address width of the memory read port and of start_addr.
- DATA_W, 32: word width. Byte address stride per word is DATA_W/8.
- CNT_W, 16: width of word_count, which can request up to 2^CNT_W-1 words.
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command, sampled only in IDLE.
- start_addr  in  ADDR_W  first byte address, captured with start. Low log2(DATA_W/8) bits are ignored (forced 0).
- word_count  in  CNT_W  number of words, captured with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the dump completes.
- mem_rd_en  out  1  read request.
- mem_rd_addr  out  ADDR_W  read byte address.
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
- out_valid  out  1  stream word available.
- out_ready  in  1  sink accepts the word.
- out_data  out  DATA_W  dumped word.
- out_addr  out  ADDR_W  byte address of out_data.
- out_last  out  1  marks the final word of the dump.

## Operation
- States:
  - IDLE: on start with word_count≠0, go to READ. On start with word_count=0, go to DONE and emit no beats.
  - READ: issues reads. After the last read is issued, go to DRAIN.
  - DRAIN: after the last word handshake, go to DONE.
  - DONE: lasts one cycle with done=1, then returns to IDLE.
- Read pointer: rd_addr starts at start_addr and increments by DATA_W/8 per read. It wraps modulo 2^ADDR_W with no error.
- Word counters: issue_cnt counts reads still to issue; beat_cnt counts beats still to deliver.
- Output buffer: a 2-entry FIFO holds {data, addr, last}.
  - A read is issued only when (FIFO occupancy + reads in flight) < 2. Backpressure therefore never loses a word, and mem_rd_data is never stalled.
- out_last=1 on the beat where beat_cnt==1.
- A start received outside IDLE is ignored. Captured parameters do not change mid-dump.
- Reset values: state=IDLE, busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_data=0, out_addr=0, out_last=0; FIFO empty.
- Reset during a dump aborts it immediately. In-flight read data arriving on the next cycle is discarded. No done pulse is produced.

## Timing
- Start accepted in cycle T:
  - busy=1 from T+1.
  - First mem_rd_en at T+1.
  - First out_valid at T+2.
- With out_ready held high, throughput is one word per cycle. For N words:
  - The last beat is at T+N+1.
  - done is high at T+N+2.
  - busy drops at T+N+2.
  - The engine can accept a new start at T+N+3.
- word_count=0: done at T+1, busy stays 0.
- out_data, out_addr and out_last are stable while out_valid=1 and out_ready=0. out_valid does not drop without a handshake.
- Handshake occurs when out_valid & out_ready are both high in the same cycle.
- Simultaneous FIFO push (read return) and pop (handshake) in one cycle is legal; occupancy is unchanged.

## Configuration
- MEM_DUMP_CHECKSUM_EN:
  - Defined: adds output checksum [DATA_W].
    - Cleared to 0 on an accepted start.
    - Updated as checksum += out_data (mod 2^DATA_W) on each handshake.
    - Holds its value after done until the next start. Reset value 0.
  - Undefined: the checksum port and its logic are absent. All other behaviour is identical.

## Test plan
- start_addr=0x100, word_count=4, memory words 0xA0..0xA3, out_ready=1 -> beats in order:
  - addresses 0x100, 0x104, 0x108, 0x10C with data 0xA0..0xA3.
  - out_last only on 0x10C.
  - done at T+6.
  - checksum=0x286 when MEM_DUMP_CHECKSUM_EN is defined.
- Same dump with out_ready toggling 1,0,0,1,… -> identical beat sequence, no drops or duplicates, and payload held stable while stalled.
- word_count=0 -> no out_valid, no mem_rd_en, done at T+1.
- start_addr=0xFFFFFFF8, word_count=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- start pulsed again mid-dump -> ignored; the original dump completes unchanged.
- rst asserted after 2 of 8 beats -> all outputs at reset values next cycle, no done. A new dump after reset behaves normally.

Source files
------------

// File: rtl/mem_dump_ctrl.sv
// Memory-dump engine: streams a contiguous range of memory words with their addresses on a valid/ready port.
// Optional checksum output is built when MEM_DUMP_CHECKSUM_EN is defined.
module mem_dump_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [CNT_W-1:0]  i_word_count,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_rd_addr,
  input  logic [DATA_W-1:0] i_mem_rd_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic              o_out_last
`ifdef MEM_DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] o_checksum
`endif
);

  localparam int BYTES = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_rd_addr;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_beat_cnt;

  // Tag of the single read that may be in flight toward i_mem_rd_data.
  logic              r_inflight;
  logic [ADDR_W-1:0] r_if_addr;
  logic              r_if_last;

  logic [DATA_W-1:0] r_fifo_data [0:1];
  logic [ADDR_W-1:0] r_fifo_addr [0:1];
  logic              r_fifo_last [0:1];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_fifo_cnt;

  logic              w_start_acc;
  logic              w_fifo_empty;
  logic              w_credit_ok;
  logic              w_rd_issue;
  logic              w_out_valid;
  logic              w_hs;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_head_data;
  logic [ADDR_W-1:0] w_head_addr;
  logic              w_head_last;

  assign w_start_acc  = (r_state == S_IDLE) && i_start;
  assign w_fifo_empty = (r_fifo_cnt == 2'd0);
  assign w_credit_ok  = (r_fifo_cnt + {1'b0, r_inflight}) < 2'd2;
  assign w_rd_issue   = (r_state == S_READ) && w_credit_ok;

  // Returning read data is presented directly when the buffer is empty, so the
  // first beat appears the cycle the data arrives instead of a cycle later.
  assign w_out_valid  = !w_fifo_empty || r_inflight;
  assign w_hs         = w_out_valid && i_out_ready;
  assign w_push       = r_inflight && !(w_fifo_empty && w_hs);
  assign w_pop        = w_hs && !w_fifo_empty;

  assign w_head_data  = w_fifo_empty ? i_mem_rd_data : r_fifo_data[r_rd_ptr];
  assign w_head_addr  = w_fifo_empty ? r_if_addr     : r_fifo_addr[r_rd_ptr];
  assign w_head_last  = w_fifo_empty ? r_if_last     : r_fifo_last[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_word_count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (w_rd_issue && (r_issue_cnt == CNT_W'(1))) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_hs && (r_beat_cnt == CNT_W'(1))) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_addr   <= '0;
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
      r_inflight  <= 1'b0;
      r_if_addr   <= '0;
      r_if_last   <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_rd_addr   <= i_start_addr & ~ADDR_W'(BYTES - 1);
        r_issue_cnt <= i_word_count;
        r_beat_cnt  <= i_word_count;
      end else begin
        if (w_rd_issue) begin
          r_rd_addr   <= r_rd_addr + ADDR_W'(BYTES);
          r_issue_cnt <= r_issue_cnt - CNT_W'(1);
        end
        if (w_hs) begin
          r_beat_cnt <= r_beat_cnt - CNT_W'(1);
        end
      end
      r_inflight <= w_rd_issue;
      if (w_rd_issue) begin
        r_if_addr <= r_rd_addr;
        r_if_last <= (r_issue_cnt == CNT_W'(1));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_fifo_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Storage needs no reset: entries are only read when the count says valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= i_mem_rd_data;
      r_fifo_addr[r_wr_ptr] <= r_if_addr;
      r_fifo_last[r_wr_ptr] <= r_if_last;
    end
  end

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_checksum <= '0;
    end else if (w_start_acc) begin
      r_checksum <= '0;
    end else if (w_hs) begin
      r_checksum <= r_checksum + w_head_data;
    end
  end

  assign o_checksum = r_checksum;
`endif

  assign o_busy        = (r_state == S_READ) || (r_state == S_DRAIN);
  assign o_done        = (r_state == S_DONE);
  assign o_mem_rd_en   = w_rd_issue;
  assign o_mem_rd_addr = r_rd_addr;
  assign o_out_valid   = w_out_valid;
  assign o_out_data    = w_out_valid ? w_head_data : '0;
  assign o_out_addr    = w_out_valid ? w_head_addr : '0;
  assign o_out_last    = w_out_valid && w_head_last;

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Directed self-checking bench for mem_dump_ctrl; inputs driven and outputs sampled around the falling edge.
// Checksum checks are included when MEM_DUMP_CHECKSUM_EN is defined.
module tb_mem_dump_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] start_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic        mem_rd_en;
  logic [31:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic        out_last;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mem_dump_ctrl #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_start_addr (start_addr),
    .i_word_count (word_count),
    .o_busy       (busy),
    .o_done       (done),
    .o_mem_rd_en  (mem_rd_en),
    .o_mem_rd_addr(mem_rd_addr),
    .i_mem_rd_data(mem_rd_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_data   (out_data),
    .o_out_addr   (out_addr),
    .o_out_last   (out_last)
`ifdef MEM_DUMP_CHECKSUM_EN
    ,
    .o_checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: 0x100.. holds 0xA0, 0xA1, ...; elsewhere the inverted address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h140) return 32'hA0 + ((a - 32'h100) >> 2);
    return ~a;
  endfunction

  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem_word(mem_rd_addr) : 32'hBAD0BAD0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
    check({tag, "_rd_addr"}, mem_rd_addr, 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"}, out_data, 32'd0);
    check({tag, "_addr"}, out_addr, 32'd0);
    check({tag, "_last"}, 32'(out_last), 32'd0);
`ifdef MEM_DUMP_CHECKSUM_EN
    check({tag, "_checksum"}, checksum, 32'd0);
`endif
  endtask

  // k counts cycles after the start cycle T (k=1 is T+1).
  task automatic run_dump(input logic [31:0] sa, input logic [15:0] n, input bit stall, input bit poke);
    int          idx;
    int          first_v;
    int          last_b;
    int          done_c;
    bit          prev_stall;
    logic [31:0] p_data;
    logic [31:0] p_addr;
    logic        p_last;
    logic [31:0] ea;
    logic [31:0] exp_sum;
    idx = 0; first_v = -1; last_b = -1; done_c = -1; prev_stall = 1'b0;
    p_data = '0; p_addr = '0; p_last = 1'b0; exp_sum = '0;
    @(negedge clk);
    start = 1'b1; start_addr = sa; word_count = n; out_ready = 1'b1;
    #1 check("pre_busy", 32'(busy), 32'd0);
    for (int k = 1; k <= 300 && done_c < 0; k++) begin
      @(negedge clk);
      start = poke && (k == 2);
      if (poke && k == 2) begin
        start_addr = 32'h200; word_count = 16'd5;
      end
      out_ready = stall ? ((k - 1) % 3 == 0) : 1'b1;
      #1;
      if (k == 1) begin
        check("first_rd_en", 32'(mem_rd_en), 32'd1);
        check("first_rd_addr", mem_rd_addr, sa & ~32'h3);
      end
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", out_data, p_data);
        check("hold_addr", out_addr, p_addr);
        check("hold_last", 32'(out_last), 32'(p_last));
      end
      if (out_valid && first_v < 0) first_v = k;
      if (out_valid && out_ready) begin
        ea = (sa & ~32'h3) + 32'(idx) * 32'd4;
        check("beat_addr", out_addr, ea);
        check("beat_data", out_data, mem_word(ea));
        check("beat_last", 32'(out_last), 32'(idx == int'(n) - 1));
        exp_sum = exp_sum + mem_word(ea);
        idx++;
        last_b = k;
      end
      prev_stall = out_valid && !out_ready;
      p_data = out_data; p_addr = out_addr; p_last = out_last;
      if (done) begin
        done_c = k;
        check("busy_at_done", 32'(busy), 32'd0);
`ifdef MEM_DUMP_CHECKSUM_EN
        check("checksum_at_done", checksum, exp_sum);
`endif
      end else begin
        check("busy_running", 32'(busy), 32'd1);
      end
    end
    check("done_seen", 32'(done_c >= 0), 32'd1);
    check("beat_count", 32'(idx), 32'(n));
    check("done_after_last", 32'(done_c), 32'(last_b + 1));
    if (!stall) begin
      check("first_valid_cyc", 32'(first_v), 32'd2);
      check("last_beat_cyc", 32'(last_b), 32'(int'(n) + 1));
      check("done_cyc", 32'(done_c), 32'(int'(n) + 2));
    end
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    #1;
    check("post_done", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_valid", 32'(out_valid), 32'd0);
`ifdef MEM_DUMP_CHECKSUM_EN
    check("checksum_hold", checksum, exp_sum);
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; word_count = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_outs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic 4-word dump at 0x100, sink always ready.
    run_dump(32'h100, 16'd4, 1'b0, 1'b0);
`ifdef MEM_DUMP_CHECKSUM_EN
    check("checksum_0x286", checksum, 32'h286);
`endif

    // Same dump with the sink stalling two cycles out of three.
    run_dump(32'h100, 16'd4, 1'b1, 1'b0);

    // Zero-length dump: done the next cycle, no reads, no beats.
    @(negedge clk);
    start = 1'b1; start_addr = 32'h100; word_count = 16'd0; out_ready = 1'b1;
    #1 check("zero_rd_en_T", 32'(mem_rd_en), 32'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_valid", 32'(out_valid), 32'd0);
    check("zero_rd_en", 32'(mem_rd_en), 32'd0);
`ifdef MEM_DUMP_CHECKSUM_EN
    check("zero_checksum", checksum, 32'd0);
`endif
    @(negedge clk);
    #1;
    check("zero_done_end", 32'(done), 32'd0);
    check("zero_valid_end", 32'(out_valid), 32'd0);

    // Address wrap past the top of the address space.
    run_dump(32'hFFFF_FFF8, 16'd3, 1'b0, 1'b0);

    // A second start mid-dump must be ignored.
    run_dump(32'h100, 16'd6, 1'b0, 1'b1);

    // Misaligned start address is forced to a word boundary, under stalls.
    run_dump(32'h103, 16'd2, 1'b1, 1'b0);

    // Reset after two beats of an 8-word dump.
    @(negedge clk);
    start = 1'b1; start_addr = 32'h100; word_count = 16'd8; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 check("rst_beat0_addr", out_addr, 32'h100);
    @(negedge clk);
    #1 check("rst_beat1_addr", out_addr, 32'h104);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1 check_reset_outs("abort");
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_no_valid", 32'(out_valid), 32'd0);
      check("abort_no_busy", 32'(busy), 32'd0);
    end

    // Normal dump after the abort.
    run_dump(32'h120, 16'd4, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
